// File: rtl/job_loader_pkg.sv
// Shared miner definitions used by the job loader.
// Holds the loader FSM state encoding, the header layout (word order and
// indices), and the ChunkLength framing constants.
package job_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TRIG,
    ST_PAYLOAD,
    ST_DRAIN
  } state_e;

  localparam int HDR_WORDS    = 17;

  // Header word order: GroupDirections, Groups, ChunkLength, Target[0..7], Nonce[0..5]
  localparam int IDX_GDIR     = 0;
  localparam int IDX_GROUPS   = 1;
  localparam int IDX_CHUNK    = 2;
  localparam int IDX_TARGET   = 3;
  localparam int IDX_NONCE    = 11;
  localparam int TARGET_WORDS = 8;
  localparam int NONCE_WORDS  = 6;

  // ChunkLength counts bytes: a fixed 24-byte nonce area followed by 4-byte payload words
  localparam int MIN_CHUNK    = 28;
  localparam int NONCE_BYTES  = 24;

endpackage

// File: rtl/job_loader_if.sv
// Job-stream handshake bundle.
//   S_Valid_I / S_Data_I / S_Last_I : word, qualifier and end-of-frame marker
//   S_Ready_O                       : loader accepts the word this cycle
// master = stream source, slave = job_loader.
interface job_loader_if;
  logic        S_Valid_I;
  logic [31:0] S_Data_I;
  logic        S_Last_I;
  logic        S_Ready_O;

  modport master (output S_Valid_I, S_Data_I, S_Last_I, input S_Ready_O);
  modport slave  (input S_Valid_I, S_Data_I, S_Last_I, output S_Ready_O);
endinterface

// File: rtl/job_loader.sv
// Job loader: parses a framed job stream into a header (shadowed, then
// committed atomically with a one-cycle UpdateTrigger_O pulse) followed by
// payload words written to miner memory.
// Ports:
//   Clk, Rst_n (async, active-low)
//   s               : job stream (slave side of job_loader_if)
//   ErrClr_I        : clears the sticky Err_O
//   GroupDirections_O, Groups_O, ChunkLength_O, Target_O, Nonce_O : committed job
//   UpdateTrigger_O : job-commit pulse
//   Wr_O, Data_O    : miner memory write strobe/data (one cycle after acceptance)
//   Busy_O, Err_O, JobCount_O : status
module job_loader #(
  parameter int MAX_WORDS = 66,
  parameter int HDR_WORDS = 17
) (
  input  logic             Clk,
  input  logic             Rst_n,
  job_loader_if.slave      s,
  input  logic             ErrClr_I,
  output logic [31:0]      GroupDirections_O,
  output logic [31:0]      Groups_O,
  output logic [31:0]      ChunkLength_O,
  output logic [7:0][31:0] Target_O,
  output logic [5:0][31:0] Nonce_O,
  output logic             UpdateTrigger_O,
  output logic             Wr_O,
  output logic [31:0]      Data_O,
  output logic             Busy_O,
  output logic             Err_O,
  output logic [31:0]      JobCount_O
);
  import job_loader_pkg::*;

  localparam int IDX_W = $clog2(HDR_WORDS);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        shadow_q [HDR_WORDS];
  logic [31:0]        shadow_d [HDR_WORDS];
  logic [31:0]        commit_q [HDR_WORDS];
  logic [31:0]        commit_d [HDR_WORDS];
  logic               trig_q, trig_d;
  logic               wr_q, wr_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        jobs_q, jobs_d;
  logic               err_q, err_d;

  logic               acc, err_set, chunk_ok;
  logic [31:0]        chunk, pay_words;

  // Ready drops during reset and for the single commit cycle.
  assign s.S_Ready_O = Rst_n && (state_q != ST_TRIG);
  assign acc         = s.S_Valid_I && s.S_Ready_O;

  // ChunkLength is header word 2, so it is already in the shadow bank when
  // the final header word arrives.
  assign chunk     = shadow_q[IDX_CHUNK];
  assign chunk_ok  = (chunk >= 32'(MIN_CHUNK)) &&
                     (chunk <= 32'(NONCE_BYTES + 4*MAX_WORDS)) &&
                     (chunk[1:0] == 2'b00);
  assign pay_words = (chunk - 32'(NONCE_BYTES)) >> 2;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    commit_d = commit_q;
    trig_d   = 1'b0;
    wr_d     = 1'b0;
    data_d   = data_q;
    jobs_d   = jobs_q;
    err_set  = 1'b0;
    case (state_q)
      // idx_q is 0 in IDLE, so IDLE and HDR share the header capture path.
      ST_IDLE, ST_HDR: if (acc) begin
        shadow_d[idx_q] = s.S_Data_I;
        if (s.S_Last_I) begin
          err_set = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (idx_q == IDX_W'(HDR_WORDS-1)) begin
          idx_d = '0;
          if (chunk_ok) state_d = ST_TRIG;
          else begin
            err_set = 1'b1;
            state_d = ST_DRAIN;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_TRIG: begin
        commit_d = shadow_q;
        trig_d   = 1'b1;
        cnt_d    = pay_words[CNT_W-1:0];
        state_d  = ST_PAYLOAD;
      end
      ST_PAYLOAD: if (acc) begin
        wr_d   = 1'b1;
        data_d = s.S_Data_I;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (s.S_Last_I) begin
            jobs_d  = jobs_q + 32'd1;
            state_d = ST_IDLE;
          end else begin
            err_set = 1'b1;
            state_d = ST_DRAIN;
          end
        end else if (s.S_Last_I) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (acc && s.S_Last_I) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new error in the same cycle as a clear keeps the flag set.
    err_d = err_set | (err_q & ~ErrClr_I);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      jobs_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < HDR_WORDS; i++) begin
        shadow_q[i] <= '0;
        commit_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      jobs_q   <= jobs_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    GroupDirections_O = commit_q[IDX_GDIR];
    Groups_O          = commit_q[IDX_GROUPS];
    ChunkLength_O     = commit_q[IDX_CHUNK];
    for (int i = 0; i < TARGET_WORDS; i++) Target_O[i] = commit_q[IDX_TARGET+i];
    for (int i = 0; i < NONCE_WORDS; i++)  Nonce_O[i]  = commit_q[IDX_NONCE+i];
  end

  assign UpdateTrigger_O = trig_q;
  assign Wr_O            = wr_q;
  assign Data_O          = data_q;
  assign Busy_O          = (state_q != ST_IDLE);
  assign Err_O           = err_q;
  assign JobCount_O      = jobs_q;

endmodule

// File: tb/tb_job_loader.sv
// Testbench for job_loader: directed frames plus randomized frames, checked by
// a scoreboard (expected writes/commits queued at stimulus time, popped by a
// monitor when the DUT strobes Wr_O / UpdateTrigger_O) and a frame-level model.
module tb_job_loader;

  localparam int MAXW = 66;
  typedef logic [16:0][31:0] hdr_t;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             ErrClr_I = 1'b0;
  logic [31:0]      GroupDirections_O, Groups_O, ChunkLength_O, Data_O, JobCount_O;
  logic [7:0][31:0] Target_O;
  logic [5:0][31:0] Nonce_O;
  logic             UpdateTrigger_O, Wr_O, Busy_O, Err_O;

  job_loader_if jif();

  job_loader #(.MAX_WORDS(MAXW), .HDR_WORDS(17)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .s(jif), .ErrClr_I(ErrClr_I),
    .GroupDirections_O(GroupDirections_O), .Groups_O(Groups_O),
    .ChunkLength_O(ChunkLength_O), .Target_O(Target_O), .Nonce_O(Nonce_O),
    .UpdateTrigger_O(UpdateTrigger_O), .Wr_O(Wr_O), .Data_O(Data_O),
    .Busy_O(Busy_O), .Err_O(Err_O), .JobCount_O(JobCount_O)
  );

  always #5 Clk = ~Clk;

  int          checks = 0, passed = 0;
  int          ready_low = 0, exp_commits = 0;
  logic [31:0] exp_wr_q[$];
  hdr_t        exp_trig_q[$];
  hdr_t        committed_m = '0;
  logic [31:0] jobs_m = '0;
  logic        err_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_hdr(input string nm, input hdr_t h);
    chk({nm, "_gdir"},   GroupDirections_O, h[0]);
    chk({nm, "_groups"}, Groups_O,          h[1]);
    chk({nm, "_chunk"},  ChunkLength_O,     h[2]);
    for (int i = 0; i < 8; i++) chk({nm, "_target"}, Target_O[i], h[3+i]);
    for (int i = 0; i < 6; i++) chk({nm, "_nonce"},  Nonce_O[i],  h[11+i]);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or commit.
  always @(negedge Clk) begin
    hdr_t h;
    if (Rst_n) begin
      if (!jif.S_Ready_O) ready_low++;
      if (Wr_O) begin
        if (exp_wr_q.size() == 0) chk("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
        else chk("wr_data", Data_O, exp_wr_q.pop_front());
      end
      if (UpdateTrigger_O) begin
        if (exp_trig_q.size() == 0) chk("trig_expected", 32'(exp_trig_q.size() > 0), 32'd1);
        else begin
          h = exp_trig_q.pop_front();
          chk_hdr("commit", h);
        end
      end
    end
  end

  // Frame-level reference: a frame is a word list whose only S_Last_I is on
  // its final word. Decides commit, written words, error and job count.
  task automatic model_frame(input logic [31:0] w[$]);
    int     n = w.size();
    longint c = longint'(w[2]);
    int     p, nw;
    hdr_t   h;
    if (n <= 17 || c < 28 || c > 24 + 4*MAXW || (c % 4) != 0) begin
      err_m = 1'b1;
      return;
    end
    p = int'((c - 24) / 4);
    for (int i = 0; i < 17; i++) h[i] = w[i];
    exp_trig_q.push_back(h);
    committed_m = h;
    exp_commits++;
    nw = (n - 17 < p) ? n - 17 : p;
    for (int i = 0; i < nw; i++) exp_wr_q.push_back(w[17+i]);
    if (n == 17 + p) jobs_m = jobs_m + 32'd1;
    else err_m = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int duty, input logic clr);
    int n = 0;
    while ($urandom_range(99) >= duty) begin
      jif.S_Valid_I = 1'b0;
      @(posedge Clk); #1;
    end
    jif.S_Valid_I = 1'b1;
    jif.S_Data_I  = d;
    jif.S_Last_I  = l;
    ErrClr_I      = clr;
    forever begin
      @(negedge Clk);
      if (jif.S_Ready_O) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL ready_timeout: ready low for %0d cycles, required high", n);
        break;
      end
    end
    @(posedge Clk); #1;
    jif.S_Valid_I = 1'b0;
    jif.S_Last_I  = 1'b0;
    ErrClr_I      = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[$], input int duty, input int clr_idx,
                            input bit tail_last);
    for (int i = 0; i < w.size(); i++)
      send_word(w[i], tail_last && (i == w.size()-1), duty, i == clr_idx);
  endtask

  task automatic post_check(input string nm);
    repeat (3) @(posedge Clk);
    #1;
    chk({nm, "_err"},  32'(Err_O),  32'(err_m));
    chk({nm, "_jobs"}, JobCount_O,  jobs_m);
    chk({nm, "_busy"}, 32'(Busy_O), 32'd0);
    chk_hdr({nm, "_held"}, committed_m);
  endtask

  task automatic clear_err();
    ErrClr_I = 1'b1;
    @(posedge Clk); #1;
    ErrClr_I = 1'b0;
    err_m = 1'b0;
    chk("err_clear", 32'(Err_O), 32'd0);
  endtask

  // Header with random fields and a given ChunkLength, then npay payload words.
  task automatic make_frame(input logic [31:0] chunk, input int npay, output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < 17 + npay; i++) w.push_back($urandom());
    w[2] = chunk;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] bad [5];
    int kind, p, n;
    bad[0] = 32'd26; bad[1] = 32'd30; bad[2] = 32'd20; bad[3] = 32'd292; bad[4] = 32'd0;
    jif.S_Valid_I = 1'b0;
    jif.S_Data_I  = '0;
    jif.S_Last_I  = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", 32'(jif.S_Ready_O), 32'd0);
    chk("rst_busy",  32'(Busy_O), 32'd0);
    chk("rst_err",   32'(Err_O), 32'd0);
    chk("rst_wr",    32'(Wr_O), 32'd0);
    chk("rst_trig",  32'(UpdateTrigger_O), 32'd0);
    chk("rst_data",  Data_O, 32'd0);
    chk("rst_jobs",  JobCount_O, 32'd0);
    chk_hdr("rst", '0);
    #10 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("ready_after_rst", 32'(jif.S_Ready_O), 32'd1);

    // Full-size job streamed back-to-back
    make_frame(32'd288, 66, w);
    model_frame(w);
    send_frame(w, 100, -1, 1'b1);
    post_check("max_job");

    // Undersized ChunkLength: error, previous commit held
    make_frame(32'd26, 0, w);
    model_frame(w);
    send_frame(w, 100, -1, 1'b1);
    post_check("short_chunk");
    clear_err();

    // S_Last_I on payload word 10 of 66, then a normal job
    make_frame(32'd288, 10, w);
    model_frame(w);
    send_frame(w, 100, -1, 1'b1);
    post_check("early_last");
    make_frame(32'd100, 19, w);
    model_frame(w);
    send_frame(w, 100, -1, 1'b1);
    post_check("after_early");
    clear_err();

    // Clear coinciding with a header error: the error wins
    make_frame(32'd30, 3, w);
    model_frame(w);
    send_frame(w, 100, 16, 1'b1);
    post_check("clr_vs_set");
    clear_err();

    // Randomized frames at ~30% valid duty
    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(8);
      p = $urandom_range(1, 20);
      if (kind <= 4) make_frame(32'(24 + 4*p), p, w);
      else if (kind == 5) make_frame(bad[$urandom_range(4)], $urandom_range(0, 5), w);
      else if (kind == 6) begin
        make_frame(32'(24 + 4*p), 0, w);
        n = $urandom_range(3, 17);
        while (w.size() > n) void'(w.pop_back());
      end else if (kind == 7) begin
        if (p < 2) p = 2;
        make_frame(32'(24 + 4*p), $urandom_range(1, p-1), w);
      end else begin
        make_frame(32'(24 + 4*p), p + $urandom_range(1, 3), w);
      end
      model_frame(w);
      send_frame(w, 30, -1, 1'b1);
      post_check("rand");
      if ($urandom_range(1) == 1) clear_err();
    end
    chk("ready_low_per_job", 32'(ready_low), 32'(exp_commits));

    // Reset during payload word 5: outputs drop at once, then a minimal job
    make_frame(32'd288, 5, w);
    begin
      hdr_t h;
      for (int i = 0; i < 17; i++) h[i] = w[i];
      exp_trig_q.push_back(h);
      for (int i = 0; i < 5; i++) exp_wr_q.push_back(w[17+i]);
      exp_commits++;
    end
    send_frame(w, 100, -1, 1'b0);
    @(negedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(jif.S_Ready_O), 32'd0);
    chk("mid_rst_busy",  32'(Busy_O), 32'd0);
    chk("mid_rst_wr",    32'(Wr_O), 32'd0);
    chk("mid_rst_data",  Data_O, 32'd0);
    chk("mid_rst_jobs",  JobCount_O, 32'd0);
    chk_hdr("mid_rst", '0);
    committed_m = '0;
    jobs_m = '0;
    err_m = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    make_frame(32'd28, 1, w);
    model_frame(w);
    send_frame(w, 100, -1, 1'b1);
    post_check("after_rst");

    repeat (3) @(posedge Clk);
    #1;
    chk("wr_queue_drained",   32'(exp_wr_q.size()), 32'd0);
    chk("trig_queue_drained", 32'(exp_trig_q.size()), 32'd0);
    chk("ready_low_total",    32'(ready_low), 32'(exp_commits));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/job_loader.md
JOB_LOADER -- requirements
Module: job_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 66: maximum payload words, equal to miner memory depth.
REQ-002 SHALL have parameter HDR_WORDS, default 17: header words per job.
REQ-003 SHALL have port Clk, input, 1: clock.
REQ-004 SHALL have port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port S_Valid_I, input, 1: job-stream word valid.
REQ-006 SHALL have port S_Data_I, input, 32: job-stream word.
REQ-007 SHALL have port S_Last_I, input, 1: last word of job frame.
REQ-008 SHALL have port S_Ready_O, output, 1: loader accepts the word.
REQ-009 SHALL have port ErrClr_I, input, 1: clears Err_O.
REQ-010 SHALL have ports GroupDirections_O, Groups_O and ChunkLength_O, output, 32 each: committed job fields.
REQ-011 SHALL have ports Target_O (8x32) and Nonce_O (6x32), output: committed target and start nonce.
REQ-012 SHALL have port UpdateTrigger_O, output, 1: one-cycle job-commit pulse to the miner.
REQ-013 SHALL have ports Wr_O, output, 1, and Data_O, output, 32: miner memory write strobe and data.
REQ-014 SHALL have ports Busy_O, output, 1; Err_O, output, 1 (sticky frame error); and JobCount_O, output, 32 (jobs committed).

Function
REQ-015 SHALL accept a word when S_Valid_I && S_Ready_O.
REQ-016 SHALL take the header word order as: GroupDirections, Groups, ChunkLength, Target[0..7], Nonce[0..5].
REQ-017 SHALL write the header into shadow registers; committed outputs SHALL NOT change until commit.
REQ-018 SHALL implement the FSM IDLE -> HDR -> TRIG -> PAYLOAD -> IDLE, plus a DRAIN state.
- IDLE: the first accepted word is header word 0 -> HDR.
- HDR: after word HDR_WORDS-1 is accepted -> TRIG, or -> DRAIN on error.
REQ-019 SHALL check the shadow ChunkLength at the end of HDR:
- valid when ChunkLength >= 28, ChunkLength <= 24+4*MAX_WORDS and ChunkLength[1:0] == 0;
- otherwise set Err_O and go to DRAIN.
REQ-020 In TRIG, SHALL hold S_Ready_O low and, for exactly one cycle:
- copy shadow registers to the committed outputs;
- pulse UpdateTrigger_O;
- load the payload counter with (ChunkLength-24)>>2;
- then go to PAYLOAD.
REQ-021 In PAYLOAD, each accepted word SHALL drive Wr_O=1 and Data_O=word on the next cycle (latency 1) and decrement the counter.
REQ-022 On acceptance of the word that brings the counter to 0, SHALL go to IDLE and increment JobCount_O (wraps at 2^32).
REQ-023 S_Last_I SHALL be asserted on the final payload word; on a mismatch SHALL set Err_O:
- S_Last_I on any header word, or on a payload word with counter != 1 -> IDLE;
- final payload word without S_Last_I -> DRAIN.
REQ-024 DRAIN SHALL accept and discard words, with Wr_O=0, until a word with S_Last_I is accepted, then go to IDLE.
REQ-025 S_Ready_O SHALL be 1 in IDLE, HDR, PAYLOAD and DRAIN, and 0 in TRIG.
REQ-026 Busy_O SHALL equal (state != IDLE).
REQ-027 Err_O SHALL be set by any frame error and cleared by ErrClr_I; a simultaneous set wins.
REQ-028 An aborted header SHALL leave the committed outputs, JobCount_O and Wr_O unchanged.
REQ-029 Data_O SHALL hold its last value when Wr_O=0.

Reset
REQ-030 On Rst_n low, SHALL immediately (asynchronously) force:
- FSM to IDLE and all counters to 0;
- S_Ready_O=0 while in reset, then 1;
- all committed outputs, Data_O and JobCount_O to 0;
- UpdateTrigger_O=0, Wr_O=0, Busy_O=0, Err_O=0.
REQ-031 Reset mid-frame SHALL discard the frame; the first word accepted after reset is treated as header word 0.

Structure
REQ-032 SHALL place in the shared miner package: the FSM state enum, HDR_WORDS, the header index constants, and MIN_CHUNK=28 / NONCE_BYTES=24.
REQ-033 SHALL be a single module with no sub-modules; the shadow and committed register banks SHALL be plain arrays.

Verification
REQ-034 SHALL pass a valid job with ChunkLength=288 (66 words), words streamed back-to-back:
- one UpdateTrigger_O pulse after the 17th word;
- 66 Wr_O pulses with data in order;
- JobCount_O=1.
REQ-035 SHALL pass a header with ChunkLength=26: Err_O=1, no UpdateTrigger_O, no Wr_O, and committed outputs equal to the previous job.
REQ-036 SHALL pass a frame with S_Last_I on payload word 10 of 66:
- Err_O=1, FSM in IDLE;
- the next valid job commits normally, with JobCount_O incremented by 1.
REQ-037 SHALL pass a random S_Valid_I duty of 30%:
- Wr_O count equals accepted payload words;
- S_Ready_O is low exactly one cycle per job.
REQ-038 SHALL pass Rst_n asserted at payload word 5:
- all outputs go to 0 immediately;
- a following job with ChunkLength=28 gives 1 Wr_O pulse and JobCount_O=1.
REQ-039 SHALL pass ErrClr_I and an error event in the same cycle: Err_O remains 1.
